spi_word_rx: RTL and testbench

Serial front end of the function-generator control path. It receives 16-bit words from the host SPI bus, which runs in mode 0, MSB first. Each completed word is presented on Dout with a one-cycle Valid strobe. Dout and Valid feed the Din and EN inputs of the downstream 16-bit enable latch. All logic runs in the Clock domain; the SPI pins are oversampled.

---
 rtl/afg_spi_pkg.sv | 15 +
 rtl/spi_word_rx_if.sv | 28 ++
 rtl/sync_edge_detect.sv | 36 +++
 rtl/spi_word_rx.sv | 133 +++++++++++++
 tb/tb_spi_word_rx.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/afg_spi_pkg.sv
// Shared constants and state encoding for the SPI word receiver.
//   SPI_DATA_WIDTH : bits per received word
//   SPI_CNT_WIDTH  : bit-counter width (must hold SPI_DATA_WIDTH)
//   spi_state_e    : receiver frame state
package afg_spi_pkg;

   localparam int unsigned SPI_DATA_WIDTH = 16;
   localparam int unsigned SPI_CNT_WIDTH  = 5;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } spi_state_e;

endpackage

// File: rtl/spi_word_rx_if.sv
// SPI pins plus the received-word output bundle.
//   master : SPI host / word consumer side (drives SCLK, CS_n, MOSI)
//   slave  : receiver side (drives Dout, Valid, Busy, FrameErr)
interface spi_word_rx_if
   import afg_spi_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = SPI_DATA_WIDTH
);

   logic                  SCLK;
   logic                  CS_n;
   logic                  MOSI;
   logic [DATA_WIDTH-1:0] Dout;
   logic                  Valid;
   logic                  Busy;
   logic                  FrameErr;

   modport master (
      output SCLK, CS_n, MOSI,
      input  Dout, Valid, Busy, FrameErr
   );

   modport slave (
      input  SCLK, CS_n, MOSI,
      output Dout, Valid, Busy, FrameErr
   );

endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for one asynchronous input plus rise/fall detection.
//   Clock, Reset : system clock, synchronous active-low reset
//   async_in     : asynchronous input pin
//   sync_out     : synchronized level
//   rise, fall   : one-cycle edge indications on sync_out (suppressed in reset)
module sync_edge_detect #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic Clock,
   input  logic Reset,
   input  logic async_in,
   output logic sync_out,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   hist_q, hist_d;

   // Synchronizer keeps sampling through reset and history tracks it, so
   // leaving reset compares like with like and shows no false edge.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
      hist_d = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge Clock) begin
      sync_q <= sync_d;
      hist_q <= hist_d;
   end

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign rise     = Reset &  sync_out & ~hist_q;
   assign fall     = Reset & ~sync_out &  hist_q;

endmodule

// File: rtl/spi_word_rx.sv
// SPI mode-0, MSB-first word receiver oversampled in the Clock domain.
//   Clock, Reset : system clock, synchronous active-low reset
//   bus.SCLK/CS_n/MOSI : asynchronous SPI pins
//   bus.Dout     : last completed word (held until the next one)
//   bus.Valid    : one-cycle strobe for a new Dout
//   bus.Busy     : frame open
//   bus.FrameErr : one-cycle strobe, CS_n rose mid-word
module spi_word_rx
   import afg_spi_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = SPI_DATA_WIDTH,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_WIDTH   = SPI_CNT_WIDTH
) (
   input  logic          Clock,
   input  logic          Reset,
   spi_word_rx_if.slave  bus
);

   localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DATA_WIDTH);

   logic sclk_sync, sclk_rise, sclk_fall;
   logic cs_sync, cs_rise, cs_fall;

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
      .Clock    (Clock),
      .Reset    (Reset),
      .async_in (bus.SCLK),
      .sync_out (sclk_sync),
      .rise     (sclk_rise),
      .fall     (sclk_fall)
   );

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
      .Clock    (Clock),
      .Reset    (Reset),
      .async_in (bus.CS_n),
      .sync_out (cs_sync),
      .rise     (cs_rise),
      .fall     (cs_fall)
   );

   // Edge-detector outputs this block has no use for.
   logic unused_edge_sigs;
   assign unused_edge_sigs = &{1'b0, sclk_sync, sclk_fall, cs_sync};

   // MOSI chain of equal depth keeps data aligned with the SCLK edge.
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   mosi_sync;

   always_comb mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.MOSI};
   always_ff @(posedge Clock) mosi_sync_q <= mosi_sync_d;
   assign mosi_sync = mosi_sync_q[SYNC_STAGES-1];

   spi_state_e            state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  valid_q, valid_d;
   logic                  frame_err_q, frame_err_d;
   logic                  word_done;
   logic [CNT_WIDTH-1:0]  cnt_base, cnt_upd;

   // A full count is retired one cycle after the last bit lands; this also
   // covers a word whose last bit coincided with CS_n rising.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      dout_d      = dout_q;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;
      word_done   = (cnt_q == CNT_FULL);
      cnt_base    = word_done ? '0 : cnt_q;
      cnt_upd     = cnt_base;

      if (word_done) begin
         dout_d  = shift_q;
         valid_d = 1'b1;
         cnt_d   = cnt_base;
      end

      case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               state_d = ST_SHIFT;
               cnt_d   = '0;
               shift_d = '0;
            end
         end
         ST_SHIFT: begin
            if (sclk_rise) begin
               shift_d = {shift_q[DATA_WIDTH-2:0], mosi_sync};
               cnt_upd = cnt_base + CNT_WIDTH'(1);
            end
            cnt_d = cnt_upd;
            // End-of-frame check sees the count after this cycle's bit.
            if (cs_rise) begin
               state_d     = ST_IDLE;
               frame_err_d = (cnt_upd != '0) && (cnt_upd != CNT_FULL) && !valid_d;
               if (frame_err_d) begin
                  cnt_d = '0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         dout_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         dout_q      <= dout_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign bus.Dout     = dout_q;
   assign bus.Valid    = valid_q;
   assign bus.Busy     = (state_q == ST_SHIFT);
   assign bus.FrameErr = frame_err_q;

endmodule

// File: tb/tb_spi_word_rx.sv
// Self-checking bench for spi_word_rx: a pin-level SPI host with an
// event-time model of when words, frame errors and busy changes must appear.
module tb_spi_word_rx;

   localparam int unsigned DW   = 16;
   localparam int          SYNC = 2;

   logic Clock = 1'b0;
   logic Reset;

   always #5 Clock = ~Clock;

   spi_word_rx_if #(.DATA_WIDTH(DW)) bus ();

   spi_word_rx #(
      .DATA_WIDTH  (DW),
      .SYNC_STAGES (SYNC),
      .CNT_WIDTH   (5)
   ) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   typedef struct {
      int          cyc;
      logic [15:0] word;
   } vev_t;

   typedef struct {
      int cyc;
      bit val;
   } bev_t;

   vev_t        vq[$];
   int          fq[$];
   bev_t        bq[$];
   int          cyc      = 0;
   int          checks   = 0;
   int          errors   = 0;
   bit          checking = 1'b0;
   logic [15:0] dout_model = '0;
   bit          busy_exp = 1'b0;
   bit          frame_open = 1'b0;
   int          mbits = 0;
   logic [15:0] macc = '0;
   int          half = 4;
   int          n_valid = 0;
   int          n_ferr = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // Per-cycle comparison against the event-time model.
   always @(posedge Clock) begin
      bit ev, ef;
      #1;
      cyc++;
      if (checking) begin
         if (!Reset) begin
            dout_model = '0;
            busy_exp   = 1'b0;
         end
         while (bq.size() > 0 && bq[0].cyc <= cyc) begin
            busy_exp = bq[0].val;
            void'(bq.pop_front());
         end
         ev = (vq.size() > 0 && vq[0].cyc == cyc);
         if (ev) begin
            dout_model = vq[0].word;
            void'(vq.pop_front());
         end
         ef = (fq.size() > 0 && fq[0] == cyc);
         if (ef) void'(fq.pop_front());
         if (bus.Valid === 1'b1)    n_valid++;
         if (bus.FrameErr === 1'b1) n_ferr++;
         chk("valid",    32'(bus.Valid),    32'(ev));
         chk("frameerr", 32'(bus.FrameErr), 32'(ef));
         chk("dout",     32'(bus.Dout),     32'(dout_model));
         chk("busy",     32'(bus.Busy),     32'(busy_exp));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge Clock);
   endtask

   task automatic cs_drop();
      bev_t e;
      bus.CS_n   = 1'b0;
      frame_open = 1'b1;
      mbits      = 0;
      e.cyc = cyc + SYNC + 1;
      e.val = 1'b1;
      bq.push_back(e);
      tick(half);
   endtask

   task automatic cs_raise();
      bev_t e;
      bus.CS_n = 1'b1;
      if (frame_open && mbits != 0) fq.push_back(cyc + SYNC + 1);
      frame_open = 1'b0;
      mbits      = 0;
      e.cyc = cyc + SYNC + 1;
      e.val = 1'b0;
      bq.push_back(e);
   endtask

   task automatic send_bit(input bit b, input bit end_frame);
      vev_t v;
      bus.MOSI = b;
      tick(half);
      bus.SCLK = 1'b1;
      if (frame_open) begin
         macc = {macc[14:0], b};
         mbits++;
         if (mbits == DW) begin
            v.cyc  = cyc + SYNC + 2;
            v.word = macc;
            vq.push_back(v);
            mbits = 0;
         end
      end
      if (end_frame) cs_raise();
      tick(half);
      bus.SCLK = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] w, input int nbits, input bit end_frame);
      for (int i = 0; i < nbits; i++) begin
         send_bit(w[15-i], end_frame && (i == nbits - 1));
      end
   endtask

   task automatic pulse_reset();
      Reset      = 1'b0;
      frame_open = 1'b0;
      mbits      = 0;
      tick(2);
      Reset      = 1'b1;
   endtask

   initial begin
      int v0, f0, nw, part;
      bit sim;

      Reset    = 1'b0;
      bus.CS_n = 1'b1;
      bus.SCLK = 1'b0;
      bus.MOSI = 1'b0;
      tick(2);
      chk("rst_dout",     32'(bus.Dout),     32'h0);
      chk("rst_valid",    32'(bus.Valid),    32'h0);
      chk("rst_busy",     32'(bus.Busy),     32'h0);
      chk("rst_frameerr", 32'(bus.FrameErr), 32'h0);
      Reset    = 1'b1;
      checking = 1'b1;
      tick(3);

      // Single frame at Clock/8.
      half = 4;
      v0 = n_valid; f0 = n_ferr;
      cs_drop();
      send_word(16'hA5C3, 16, 1'b0);
      tick(2);
      chk("t2_dout", 32'(bus.Dout), 32'hA5C3);
      chk("t2_busy_open", 32'(bus.Busy), 32'h1);
      cs_raise();
      tick(6);
      chk("t2_busy_closed", 32'(bus.Busy), 32'h0);
      chk("t2_valid_count", 32'(n_valid - v0), 32'd1);
      chk("t2_ferr_count",  32'(n_ferr - f0),  32'd0);

      // Two words in one frame.
      v0 = n_valid; f0 = n_ferr;
      cs_drop();
      send_word(16'h1234, 16, 1'b0);
      chk("t3_dout_first", 32'(bus.Dout), 32'h1234);
      send_word(16'hFFFF, 16, 1'b0);
      tick(2);
      chk("t3_dout_second", 32'(bus.Dout), 32'hFFFF);
      cs_raise();
      tick(6);
      chk("t3_valid_count", 32'(n_valid - v0), 32'd2);
      chk("t3_ferr_count",  32'(n_ferr - f0),  32'd0);

      // Partial word, 9 bits.
      v0 = n_valid; f0 = n_ferr;
      cs_drop();
      send_word(16'h5A5A, 9, 1'b0);
      cs_raise();
      tick(8);
      chk("t4_dout_held",   32'(bus.Dout), 32'hFFFF);
      chk("t4_ferr_count",  32'(n_ferr - f0),  32'd1);
      chk("t4_valid_count", 32'(n_valid - v0), 32'd0);

      // Reset mid-frame with CS_n held low.
      cs_drop();
      send_word(16'hC3C3, 8, 1'b0);
      pulse_reset();
      v0 = n_valid; f0 = n_ferr;
      send_word(16'h3C3C, 8, 1'b0);
      tick(6);
      chk("t5_no_valid", 32'(n_valid - v0), 32'd0);
      chk("t5_no_ferr",  32'(n_ferr - f0),  32'd0);
      chk("t5_idle",     32'(bus.Busy),     32'h0);
      cs_raise();
      tick(half);
      cs_drop();
      send_word(16'h0001, 16, 1'b0);
      tick(2);
      chk("t5_dout", 32'(bus.Dout), 32'h0001);
      cs_raise();
      tick(6);

      // SCLK activity with CS_n high.
      half = 3;
      v0 = n_valid; f0 = n_ferr;
      for (int i = 0; i < 40; i++) send_bit(1'($urandom), 1'b0);
      tick(6);
      chk("t6_no_valid", 32'(n_valid - v0), 32'd0);
      chk("t6_no_ferr",  32'(n_ferr - f0),  32'd0);
      chk("t6_dout",     32'(bus.Dout),     32'h0001);

      // Last bit and CS_n rise together.
      half = 2;
      v0 = n_valid; f0 = n_ferr;
      cs_drop();
      send_word(16'hBEEF, 16, 1'b1);
      tick(6);
      chk("t7_dout",        32'(bus.Dout),     32'hBEEF);
      chk("t7_valid_count", 32'(n_valid - v0), 32'd1);
      chk("t7_ferr_count",  32'(n_ferr - f0),  32'd0);

      // Randomized frames.
      for (int f = 0; f < 25; f++) begin
         half = $urandom_range(2, 5);
         nw   = $urandom_range(0, 2);
         part = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 15) : 0;
         sim  = (part == 0) && (nw > 0) && ($urandom_range(0, 1) == 1);
         cs_drop();
         for (int k = 0; k < nw; k++) send_word(16'($urandom), 16, sim && (k == nw - 1));
         if (part != 0) send_word(16'($urandom), part, 1'b0);
         if (!sim) cs_raise();
         tick(half + 1);
      end

      tick(12);
      chk("drain_valid_events", 32'(vq.size()), 32'd0);
      chk("drain_ferr_events",  32'(fq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
